// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared FSM encoding and parameter helpers for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit sync_stages_ok(input int stages);
        return stages >= 2;
    endfunction

    function automatic bit seq_params_ok(input int stages, input int num_out,
                                         input int min_assert, input int gap);
        return sync_stages_ok(stages) && (num_out >= 1) && (min_assert >= 1) && (gap >= 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - async-assert / clk-synchronised-release flop chain for the external reset
module reset_sync
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sync_ok
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
        $error("reset_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - stretches reset to a minimum width then releases domains in order
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 3,
    parameter int MIN_ASSERT  = 4,
    parameter int GAP         = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               rst_done
);

    localparam int CNT_W = $clog2(max2(MIN_ASSERT, GAP) + 1);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] ONE_HOT0  = NUM_OUT'(1);

    if (!seq_params_ok(SYNC_STAGES, NUM_OUT, MIN_ASSERT, GAP)) begin : g_bad_params
        $error("reset_sequencer: illegal parameter combination");
    end

    logic               w_sync_ok;
    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [NUM_OUT-1:0] r_rst_out, w_rst_out;
    logic               r_rst_done, w_rst_done;
    logic               w_release;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk     (clk),
        .reset   (reset),
        .sync_ok (w_sync_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ASSERT;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_out  <= '1;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_rst_out  <= w_rst_out;
            r_rst_done <= w_rst_done;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_rst_out  = r_rst_out;
        w_rst_done = r_rst_done;
        w_release  = 1'b0;

        case (r_state)
            ST_ASSERT: begin
                if (w_sync_ok) begin
                    w_state = ST_HOLD;
                    w_cnt   = '0;
                    w_idx   = '0;
                end
            end
            ST_HOLD: begin
                // A soft request here pushes the hold window out rather than releasing.
                if (soft_rst_req) begin
                    w_cnt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_release = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!soft_rst_req) begin
                    if (r_cnt == GAP_LAST) begin
                        w_release = 1'b1;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        if ((r_state == ST_RELEASE || r_state == ST_DONE) && soft_rst_req) begin
            w_state    = ST_HOLD;
            w_cnt      = '0;
            w_idx      = '0;
            w_rst_out  = '1;
            w_rst_done = 1'b0;
        end

        // r_idx is 0 throughout HOLD, so the first release clears bit 0.
        if (w_release) begin
            w_rst_out = r_rst_out & ~(ONE_HOT0 << r_idx);
            w_cnt     = '0;
            if (r_idx == IDX_LAST) begin
                w_state    = ST_DONE;
                w_rst_done = 1'b1;
            end else begin
                w_state = ST_RELEASE;
                w_idx   = r_idx + 1'b1;
            end
        end
    end

    assign rst_out  = r_rst_out;
    assign rst_done = r_rst_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_a;
    logic       soft_a;
    logic [2:0] rst_out_a;
    logic       rst_done_a;
    logic       reset_b;
    logic       soft_b;
    logic [0:0] rst_out_b;
    logic       rst_done_b;

    int errors = 0;
    int checks = 0;
    int e      = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES(2), .NUM_OUT(3), .MIN_ASSERT(4), .GAP(3)
    ) dut_a (
        .clk          (clk),
        .reset        (reset_a),
        .soft_rst_req (soft_a),
        .rst_out      (rst_out_a),
        .rst_done     (rst_done_a)
    );

    reset_sequencer #(
        .SYNC_STAGES(3), .NUM_OUT(1), .MIN_ASSERT(1), .GAP(1)
    ) dut_b (
        .clk          (clk),
        .reset        (reset_b),
        .soft_rst_req (soft_b),
        .rst_out      (rst_out_b),
        .rst_done     (rst_done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int n);
        while (e < n) tick();
    endtask

    task automatic release_a();
        @(negedge clk);
        reset_a = 1'b0;
        e = 0;
    endtask

    task automatic soft_at(input int n);
        run_to(n - 1);
        soft_a = 1'b1;
        run_to(n);
        soft_a = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] exp_out, input logic exp_done);
        checks++;
        assert (rst_out_a === exp_out) else begin
            errors++;
            $error("FAIL %s edge %0d rst_out observed=%b expected=%b", tag, e, rst_out_a, exp_out);
        end
        checks++;
        assert (rst_done_a === exp_done) else begin
            errors++;
            $error("FAIL %s edge %0d rst_done observed=%b expected=%b", tag, e, rst_done_a, exp_done);
        end
    endtask

    task automatic chk_b(input string tag, input logic exp_out, input logic exp_done);
        checks++;
        assert (rst_out_b[0] === exp_out) else begin
            errors++;
            $error("FAIL %s edge %0d rst_out observed=%b expected=%b", tag, e, rst_out_b[0], exp_out);
        end
        checks++;
        assert (rst_done_b === exp_done) else begin
            errors++;
            $error("FAIL %s edge %0d rst_done observed=%b expected=%b", tag, e, rst_done_b, exp_done);
        end
    endtask

    initial begin
        reset_a = 1'b1;
        soft_a  = 1'b0;
        reset_b = 1'b1;
        soft_b  = 1'b0;

        // Power-up
        repeat (3) tick();
        chk_a("pwr_in_reset", 3'b111, 1'b0);
        release_a();
        run_to(2);  chk_a("pwr_e2", 3'b111, 1'b0);
        run_to(6);  chk_a("pwr_e6", 3'b111, 1'b0);
        run_to(7);  chk_a("pwr_e7", 3'b110, 1'b0);
        run_to(9);  chk_a("pwr_e9", 3'b110, 1'b0);
        run_to(10); chk_a("pwr_e10", 3'b100, 1'b0);
        run_to(12); chk_a("pwr_e12", 3'b100, 1'b0);
        run_to(13); chk_a("pwr_e13", 3'b000, 1'b1);
        run_to(18); chk_a("pwr_e18", 3'b000, 1'b1);

        // Soft request from DONE
        soft_at(20); chk_a("soft_e20", 3'b111, 1'b0);
        run_to(23); chk_a("soft_e23", 3'b111, 1'b0);
        run_to(24); chk_a("soft_e24", 3'b110, 1'b0);
        run_to(27); chk_a("soft_e27", 3'b100, 1'b0);
        run_to(29); chk_a("soft_e29", 3'b100, 1'b0);
        run_to(30); chk_a("soft_e30", 3'b000, 1'b1);

        // Sub-period async reset pulse mid-RELEASE, then restart
        reset_a = 1'b1;
        repeat (2) tick();
        release_a();
        run_to(11); chk_a("pulse_pre", 3'b100, 1'b0);
        #3;
        reset_a = 1'b1;
        #1;
        chk_a("pulse_async", 3'b111, 1'b0);
        #1;
        reset_a = 1'b0;
        e = 0;
        run_to(6);  chk_a("pulse_e6", 3'b111, 1'b0);
        run_to(7);  chk_a("pulse_e7", 3'b110, 1'b0);
        run_to(10); chk_a("pulse_e10", 3'b100, 1'b0);
        run_to(13); chk_a("pulse_e13", 3'b000, 1'b1);

        // Soft at 20 then again at 22 while in HOLD
        soft_at(20); chk_a("dbl_e20", 3'b111, 1'b0);
        soft_at(22); chk_a("dbl_e22", 3'b111, 1'b0);
        run_to(24); chk_a("dbl_e24", 3'b111, 1'b0);
        run_to(25); chk_a("dbl_e25", 3'b111, 1'b0);
        run_to(26); chk_a("dbl_e26", 3'b110, 1'b0);
        run_to(28); chk_a("dbl_e28", 3'b110, 1'b0);
        run_to(29); chk_a("dbl_e29", 3'b100, 1'b0);
        run_to(31); chk_a("dbl_e31", 3'b100, 1'b0);
        run_to(32); chk_a("dbl_e32", 3'b000, 1'b1);

        // Soft held during ASSERT is ignored
        reset_a = 1'b1;
        repeat (2) tick();
        release_a();
        soft_a = 1'b1;
        run_to(3);
        soft_a = 1'b0;
        chk_a("ign_e3", 3'b111, 1'b0);
        run_to(6);  chk_a("ign_e6", 3'b111, 1'b0);
        run_to(7);  chk_a("ign_e7", 3'b110, 1'b0);
        run_to(10); chk_a("ign_e10", 3'b100, 1'b0);
        run_to(13); chk_a("ign_e13", 3'b000, 1'b1);

        // Soft on the same edge as a scheduled release keeps the bit asserted
        soft_at(17); chk_a("coll_e17", 3'b111, 1'b0);
        soft_at(21); chk_a("coll_e21", 3'b111, 1'b0);
        run_to(24); chk_a("coll_e24", 3'b111, 1'b0);
        run_to(25); chk_a("coll_e25", 3'b110, 1'b0);

        // Single-output instance: 3 sync stages, minimum widths
        chk_b("b_in_reset", 1'b1, 1'b0);
        @(negedge clk);
        reset_b = 1'b0;
        e = 0;
        run_to(4); chk_b("b_e4", 1'b1, 1'b0);
        run_to(5); chk_b("b_e5", 1'b0, 1'b1);
        run_to(8); chk_b("b_e8", 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
